// File: rtl/bft_stream_sender.sv
// Transmit-side BFT leaf endpoint: wraps producer words into BFT packets,
// honours switch resend back-pressure and meters traffic against receiver credit.
module bft_stream_sender #(
   parameter int unsigned PACKET_BITS        = 49,
   parameter int unsigned PAYLOAD_BITS       = 32,
   parameter int unsigned NUM_LEAF_BITS      = 5,
   parameter int unsigned NUM_PORT_BITS      = 4,
   parameter int unsigned NUM_ADDR_BITS      = 7,
   parameter int unsigned NUM_BRAM_ADDR_BITS = 7
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
   input  logic [NUM_PORT_BITS-1:0] dest_port,
   input  logic [PAYLOAD_BITS-1:0]  din_user2sender,
   input  logic                     vld_user2sender,
   output logic                     ack_sender2user,
   output logic [PACKET_BITS-1:0]   dout_sender2bft,
   input  logic                     resend,
   input  logic [PACKET_BITS-1:0]   din_bft2sender,
   output logic [NUM_BRAM_ADDR_BITS:0] credit
);

   localparam int unsigned CreditW   = NUM_BRAM_ADDR_BITS + 1;
   localparam int unsigned SumW      = CreditW + 2;
   localparam int unsigned CreditMax = 1 << NUM_BRAM_ADDR_BITS;
   localparam int unsigned PortLsb   = PAYLOAD_BITS + NUM_ADDR_BITS;

   logic [PACKET_BITS-1:0]   dout_q, dout_d;
   logic [NUM_ADDR_BITS-1:0] addr_q, addr_d;
   logic [CreditW-1:0]       credit_q, credit_d;
   logic [CreditW-1:0]       credit_inc;
   logic [SumW-1:0]          credit_sum;
   logic                     credit_pkt;
   logic                     accept;
   logic                     unused_bft;

   // Only the valid bit, port field and low payload bits of inbound packets matter.
   assign unused_bft = ^din_bft2sender;

   // Port 0 on a valid inbound packet is reserved for freespace (credit) returns.
   assign credit_pkt = din_bft2sender[PACKET_BITS-1] &&
                       (din_bft2sender[PortLsb +: NUM_PORT_BITS] == '0);
   assign credit_inc = credit_pkt ? din_bft2sender[CreditW-1:0] : '0;

   // Producer handshake: consume only with credit available and no pending resend.
   assign accept          = vld_user2sender && (credit_q != '0) && !resend;
   assign ack_sender2user = accept;
   assign dout_sender2bft = dout_q;
   assign credit          = credit_q;

   // Next packet, sequence address and saturating credit count.
   always_comb begin
      dout_d     = '0;
      addr_d     = addr_q;
      credit_sum = {2'b00, credit_q} + {2'b00, credit_inc} - {{(SumW-1){1'b0}}, accept};
      if (resend) begin
         dout_d = dout_q;
      end else if (accept) begin
         dout_d = {1'b1, dest_leaf, dest_port, addr_q, din_user2sender};
         addr_d = addr_q + 1'b1;
      end
      if (credit_sum > SumW'(CreditMax)) begin
         credit_d = CreditW'(CreditMax);
      end else begin
         credit_d = credit_sum[CreditW-1:0];
      end
   end

   // State registers; reset discards any held packet immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dout_q   <= '0;
         addr_q   <= '0;
         credit_q <= CreditW'(CreditMax);
      end else begin
         dout_q   <= dout_d;
         addr_q   <= addr_d;
         credit_q <= credit_d;
      end
   end

endmodule

// File: tb/tb_bft_stream_sender.sv
// Self-checking bench for bft_stream_sender: directed scenarios plus randomized
// traffic against a cycle-level behavioural model of the sender's rules.
module tb_bft_stream_sender;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  dest_leaf;
   logic [3:0]  dest_port;
   logic [31:0] din_user2sender;
   logic        vld_user2sender;
   logic        ack_sender2user;
   logic [48:0] dout_sender2bft;
   logic        resend;
   logic [48:0] din_bft2sender;
   logic [7:0]  credit;

   int checks   = 0;
   int failures = 0;

   // Behavioural model: current and pending expected state.
   logic [48:0] m_dout, n_dout;
   int          m_addr, n_addr, m_credit, n_credit;
   bit          m_ack;

   always #5 clk = ~clk;

   bft_stream_sender dut (
      .clk             (clk),
      .reset           (reset),
      .dest_leaf       (dest_leaf),
      .dest_port       (dest_port),
      .din_user2sender (din_user2sender),
      .vld_user2sender (vld_user2sender),
      .ack_sender2user (ack_sender2user),
      .dout_sender2bft (dout_sender2bft),
      .resend          (resend),
      .din_bft2sender  (din_bft2sender),
      .credit          (credit)
   );

   function automatic logic [48:0] pkt(input bit v, input int leaf, input int port,
                                       input int addr, input logic [31:0] pay);
      return {v, 5'(leaf), 4'(port), 7'(addr), pay};
   endfunction

   // Drive one cycle's inputs on the falling edge and compute the expected outcome.
   task automatic drive(input bit v, input logic [31:0] d, input bit rs, input logic [48:0] ib);
      int inc;
      @(negedge clk);
      vld_user2sender = v;
      din_user2sender = d;
      resend          = rs;
      din_bft2sender  = ib;
      m_ack = v && (m_credit > 0) && !rs;
      inc   = (ib[48] && ib[42:39] == 4'd0) ? int'(ib[7:0]) : 0;
      if (rs)         n_dout = m_dout;
      else if (m_ack) n_dout = pkt(1'b1, int'(dest_leaf), int'(dest_port), m_addr, d);
      else            n_dout = '0;
      n_addr   = m_ack ? (m_addr + 1) % 128 : m_addr;
      n_credit = m_credit - (m_ack ? 1 : 0) + inc;
      if (n_credit > 128) n_credit = 128;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      m_dout   = n_dout;
      m_addr   = n_addr;
      m_credit = n_credit;
   endtask

   task automatic model_reset();
      m_dout = '0; n_dout = '0;
      m_addr = 0;  n_addr = 0;
      m_credit = 128; n_credit = 128;
      m_ack = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      vld_user2sender = 1'b0;
      resend          = 1'b0;
      din_bft2sender  = '0;
      din_user2sender = '0;
      reset           = 1'b0;
      model_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic send_words(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, 32'(base + i), 1'b0, '0);
         tick();
      end
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (dout_sender2bft !== 49'd0) begin failures++;
         $display("FAIL reset_dout got=%h exp=0", dout_sender2bft); end
      checks++; if (credit !== 8'd128) begin failures++;
         $display("FAIL reset_credit got=%0d exp=128", credit); end
      checks++; if (ack_sender2user !== 1'b0) begin failures++;
         $display("FAIL reset_ack got=%b exp=0", ack_sender2user); end
   endtask

   task automatic test_stream();
      dest_leaf = 5'd7; dest_port = 4'd1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'(i), 1'b0, '0);
         checks++; if (ack_sender2user !== 1'b1) begin failures++;
            $display("FAIL stream_ack[%0d] got=%b exp=1", i, ack_sender2user); end
         tick();
         checks++; if (dout_sender2bft !== pkt(1'b1, 7, 1, i, 32'(i))) begin failures++;
            $display("FAIL stream_pkt[%0d] got=%h exp=%h", i, dout_sender2bft,
                     pkt(1'b1, 7, 1, i, 32'(i))); end
      end
      drive(1'b0, 32'hdead, 1'b0, '0);
      tick();
      checks++; if (dout_sender2bft !== 49'd0) begin failures++;
         $display("FAIL stream_idle got=%h exp=0", dout_sender2bft); end
      checks++; if (credit !== 8'd123) begin failures++;
         $display("FAIL stream_credit got=%0d exp=123", credit); end
   endtask

   task automatic test_resend();
      do_reset();
      send_words(4, 0);
      for (int c = 0; c < 2; c++) begin
         drive(1'b1, 32'd4, 1'b1, '0);
         checks++; if (ack_sender2user !== 1'b0) begin failures++;
            $display("FAIL resend_ack[%0d] got=%b exp=0", c, ack_sender2user); end
         tick();
         checks++; if (dout_sender2bft !== pkt(1'b1, 7, 1, 3, 32'd3)) begin failures++;
            $display("FAIL resend_hold[%0d] got=%h exp=%h", c, dout_sender2bft,
                     pkt(1'b1, 7, 1, 3, 32'd3)); end
      end
      drive(1'b1, 32'd4, 1'b0, '0);
      checks++; if (ack_sender2user !== 1'b1) begin failures++;
         $display("FAIL resend_release_ack got=%b exp=1", ack_sender2user); end
      tick();
      checks++; if (dout_sender2bft !== pkt(1'b1, 7, 1, 4, 32'd4)) begin failures++;
         $display("FAIL resend_next got=%h exp=%h", dout_sender2bft,
                  pkt(1'b1, 7, 1, 4, 32'd4)); end
      checks++; if (credit !== 8'd123) begin failures++;
         $display("FAIL resend_credit got=%0d exp=123", credit); end
   endtask

   task automatic test_credit_exhaust();
      do_reset();
      send_words(128, 0);
      checks++; if (credit !== 8'd0) begin failures++;
         $display("FAIL exhaust_credit got=%0d exp=0", credit); end
      checks++; if (dout_sender2bft !== pkt(1'b1, 7, 1, 127, 32'd127)) begin failures++;
         $display("FAIL exhaust_last got=%h exp=%h", dout_sender2bft,
                  pkt(1'b1, 7, 1, 127, 32'd127)); end
      drive(1'b1, 32'd128, 1'b0, '0);
      checks++; if (ack_sender2user !== 1'b0) begin failures++;
         $display("FAIL exhaust_ack got=%b exp=0", ack_sender2user); end
      tick();
      checks++; if (dout_sender2bft !== 49'd0) begin failures++;
         $display("FAIL exhaust_idle got=%h exp=0", dout_sender2bft); end
      drive(1'b1, 32'd128, 1'b0, pkt(1'b1, 0, 0, 0, 32'd64));
      checks++; if (ack_sender2user !== 1'b0) begin failures++;
         $display("FAIL return_same_cycle_ack got=%b exp=0", ack_sender2user); end
      tick();
      checks++; if (credit !== 8'd64) begin failures++;
         $display("FAIL return_credit got=%0d exp=64", credit); end
      drive(1'b1, 32'd128, 1'b0, '0);
      checks++; if (ack_sender2user !== 1'b1) begin failures++;
         $display("FAIL resume_ack got=%b exp=1", ack_sender2user); end
      tick();
      checks++; if (dout_sender2bft !== pkt(1'b1, 7, 1, 0, 32'd128)) begin failures++;
         $display("FAIL addr_wrap got=%h exp=%h", dout_sender2bft,
                  pkt(1'b1, 7, 1, 0, 32'd128)); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      send_words(28, 0);
      checks++; if (credit !== 8'd100) begin failures++;
         $display("FAIL simul_pre got=%0d exp=100", credit); end
      drive(1'b1, 32'h55, 1'b0, pkt(1'b1, 0, 0, 0, 32'd64));
      tick();
      checks++; if (credit !== 8'd128) begin failures++;
         $display("FAIL simul_sat got=%0d exp=128", credit); end
      send_words(1, 32'h56);
      drive(1'b0, 32'd0, 1'b0, pkt(1'b1, 3, 1, 0, 32'd64));
      tick();
      checks++; if (credit !== 8'd127) begin failures++;
         $display("FAIL port1_ignored got=%0d exp=127", credit); end
      drive(1'b0, 32'd0, 1'b0, pkt(1'b0, 0, 0, 0, 32'd64));
      tick();
      checks++; if (credit !== 8'd127) begin failures++;
         $display("FAIL invalid_ignored got=%0d exp=127", credit); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      send_words(128, 0);
      drive(1'b0, 32'd0, 1'b0, pkt(1'b1, 0, 0, 0, 32'd60));
      tick();
      send_words(10, 200);
      checks++; if (credit !== 8'd50) begin failures++;
         $display("FAIL mid_pre_credit got=%0d exp=50", credit); end
      drive(1'b1, 32'd999, 1'b1, '0);
      tick();
      checks++; if (dout_sender2bft !== pkt(1'b1, 7, 1, 9, 32'd209)) begin failures++;
         $display("FAIL mid_hold got=%h exp=%h", dout_sender2bft,
                  pkt(1'b1, 7, 1, 9, 32'd209)); end
      #1;
      reset = 1'b0;
      vld_user2sender = 1'b0;
      resend = 1'b0;
      model_reset();
      #1;
      checks++; if (dout_sender2bft !== 49'd0) begin failures++;
         $display("FAIL mid_async_dout got=%h exp=0", dout_sender2bft); end
      checks++; if (credit !== 8'd128) begin failures++;
         $display("FAIL mid_async_credit got=%0d exp=128", credit); end
      @(negedge clk);
      reset = 1'b1;
      drive(1'b1, 32'hab, 1'b0, '0);
      tick();
      checks++; if (dout_sender2bft !== pkt(1'b1, 7, 1, 0, 32'hab)) begin failures++;
         $display("FAIL mid_restart got=%h exp=%h", dout_sender2bft,
                  pkt(1'b1, 7, 1, 0, 32'hab)); end
      checks++; if (credit !== 8'd127) begin failures++;
         $display("FAIL mid_restart_credit got=%0d exp=127", credit); end
   endtask

   task automatic test_random();
      logic [48:0] ib;
      int          r;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      ib = pkt(1'b1, $urandom_range(0, 31), 0, $urandom_range(0, 127),
                                   32'($urandom_range(0, 255)));
         else if (r == 1) ib = pkt(1'b1, $urandom_range(0, 31), $urandom_range(1, 15),
                                   0, $urandom());
         else             ib = '0;
         if ($urandom_range(0, 15) == 0) dest_leaf = 5'($urandom_range(0, 31));
         drive($urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 5) == 0, ib);
         checks++; if (ack_sender2user !== m_ack) begin failures++;
            $display("FAIL rand_ack[%0d] got=%b exp=%b", c, ack_sender2user, m_ack); end
         tick();
         checks++; if (dout_sender2bft !== m_dout) begin failures++;
            $display("FAIL rand_dout[%0d] got=%h exp=%h", c, dout_sender2bft, m_dout); end
         checks++; if (int'(credit) !== m_credit) begin failures++;
            $display("FAIL rand_credit[%0d] got=%0d exp=%0d", c, credit, m_credit); end
      end
   endtask

   initial begin
      reset           = 1'b0;
      dest_leaf       = 5'd7;
      dest_port       = 4'd1;
      din_user2sender = '0;
      vld_user2sender = 1'b0;
      resend          = 1'b0;
      din_bft2sender  = '0;
      model_reset();
      test_reset();
      test_stream();
      test_resend();
      test_credit_exhaust();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bft_stream_sender.md
# bft_stream_sender

- Transmit-side endpoint for one leaf of the butterfly-fat-tree (BFT) network, the counterpart of the leaf interface's user→BFT receive path.
- Accepts a 32-bit word stream from a producer over the ap_vld/ap_ack handshake, wraps each word into a 49-bit BFT packet (destination leaf, port, sequence address), and drives it into the tree.
- Honours the switch's `resend` back-pressure and meters traffic against a credit counter that mirrors the receiver BRAM free space. Credits come back as freespace-update packets from the tree.

## Interface

Parameters:
- `PACKET_BITS`, 49: BFT packet width; must equal 1 + `NUM_LEAF_BITS` + `NUM_PORT_BITS` + `NUM_ADDR_BITS` + `PAYLOAD_BITS`.
- `PAYLOAD_BITS`, 32: data word width.
- `NUM_LEAF_BITS`, 5: destination-leaf field width.
- `NUM_PORT_BITS`, 4: destination-port field width.
- `NUM_ADDR_BITS`, 7: sequence-address field width.
- `NUM_BRAM_ADDR_BITS`, 7: receiver buffer depth is 2^7 = 128 words.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `dest_leaf`  in  5  target leaf; quasi-static, sampled on every accepted word.
- `dest_port`  in  4  target port on that leaf; must be nonzero (port 0 is reserved for credit returns).
- `din_user2sender`  in  32  producer data.
- `vld_user2sender`  in  1  producer data valid.
- `ack_sender2user`  out  1  combinational; the word is consumed this cycle.
- `dout_sender2bft`  out  49  packet: [48] valid, [47:43] leaf, [42:39] port, [38:32] addr, [31:0] payload.
- `resend`  in  1  from the switch; the packet on `dout_sender2bft` this cycle was dropped.
- `din_bft2sender`  in  49  inbound packets from the tree; only credit packets are consumed.
- `credit`  out  8  current credit count, 0..128.

## Operation

- `ack_sender2user` = `vld_user2sender` & (`credit` != 0) & !`resend`.
- Accepted word, registered for the next cycle:
  - `dout_sender2bft` = {1, `dest_leaf`, `dest_port`, `addr`, `din`}.
  - `addr` increments modulo 128 (127 → 0).
  - `credit` decrements by 1.
- Resend (`resend` = 1):
  - `dout_sender2bft` holds its current value the next cycle.
  - No new word is accepted.
  - `addr` and `credit` do not change.
  - Resend on consecutive cycles holds the packet indefinitely.
  - `resend` while the valid bit is 0 has no effect beyond blocking `ack_sender2user`.
- No accept and no resend: next `dout_sender2bft` = 0 (idle packet, valid bit clear).
- Credit return: packet with `din_bft2sender`[48] = 1 and port field [42:39] == 0 adds payload[7:0] to `credit`.
  - The result saturates at 128.
  - All other inbound packets are ignored.
- Simultaneous accept and credit return: next credit = min(128, credit − 1 + inc). No update is lost.
- Credit 0 blocks `ack_sender2user` even when `vld_user2sender` = 1.

## Timing

- Reset values: `dout_sender2bft` = 0, `addr` = 0, `credit` = 128, `ack_sender2user` = 0 (combinational from the reset-zero state and the gating above).
- Reset asserted mid-transfer: any held or resend-pending packet is discarded immediately and the block returns to the reset values.
- Latency:
  - Accepted word appears on `dout_sender2bft` 1 cycle after `ack_sender2user`.
  - Sustained throughput is 1 word/cycle while credit > 0 and `resend` = 0.
- Credit return: the update is visible on `credit` 1 cycle after the credit packet arrives.
- Credit reaching 0: `ack_sender2user` drops in the same cycle `credit` reads 0.

## Test plan

- **Reset and streaming:** release reset and stream words 0x0..0x4 with `vld_user2sender` held 1, `dest_leaf` = 7, `dest_port` = 1 → five packets on consecutive cycles, addr 0..4, valid = 1, `credit` ends at 123; idle packets are 0.
- **Resend:** assert `resend` for 2 cycles while packet addr 3 is on `dout_sender2bft` → it is held for 3 cycles total, `ack_sender2user` is low for 2 cycles, and addr 4 follows with no gap or duplication.
- **Credit exhaustion and return:** send 128 words with no returns → `credit` = 0 and `ack_sender2user` stays low. Inject a credit packet with port 0 and payload 64 → `credit` = 64 next cycle and streaming resumes. Addr wraps 127 → 0 on word 129.
- **Simultaneous events:** accept a word in the same cycle a 64-credit packet arrives at `credit` = 100 → `credit` = 128 (saturated). A port-1 inbound packet leaves `credit` unchanged.
- **Reset mid-operation:** pull `reset` low during resend hold with addr = 10 and `credit` = 50 → `dout_sender2bft` = 0 asynchronously; after release addr = 0 and `credit` = 128.
